// File: rtl/bip_pkg.sv
// Shared definitions for the BIP run/step/debug sequencer.
// Contents: command byte codes, snapshot frame header, controller state
// encoding, opcode field position and the halt opcode.
package bip_pkg;

   localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
   localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
   localparam logic [7:0] CMD_PRINT = 8'h50;  // 'P'
   localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
   localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'

   localparam logic [7:0] FRAME_HDR = 8'hA5;

   // BIP opcode lives in instr[15:11]
   localparam int         OP_MSB     = 15;
   localparam int         OP_LSB     = 11;
   localparam logic [4:0] HLT_OPCODE = 5'b00000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_STEP = 3'd2,
      ST_DUMP = 3'd3,
      ST_CLR  = 3'd4
   } run_state_t;

   function automatic logic [4:0] opcode_of(input logic [15:0] ins);
      return ins[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/bip_dump_ser.sv
// Snapshot frame serializer.
// Latches the cycle count on the start pulse and the CPU pc/acc one cycle
// later, then pushes the frame A5, pc_hi, pc_lo, acc_hi, acc_lo, cnt (MSB
// first) into the TX FIFO one byte per non-full cycle while active.
// Ports:
//   CLK, RESET     clock, async active-high reset
//   start          one-cycle pulse on the edge that enters DUMP
//   active         controller is in DUMP
//   pc, acc, cnt   live CPU pc/acc and post-increment cycle count
//   tx_full        TX FIFO full
//   tx_wr, tx_data TX FIFO write strobe / data
//   done           last frame byte is being written this cycle
module bip_dump_ser
   import bip_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic             active,
   input  logic [10:0]      pc,
   input  logic [15:0]      acc,
   input  logic [CNT_W-1:0] cnt,
   input  logic             tx_full,
   output logic             tx_wr,
   output logic [7:0]       tx_data,
   output logic             done
);

   localparam int CNT_BYTES = CNT_W / 8;
   localparam int N         = 5 + CNT_BYTES;
   localparam int IDX_W     = $clog2(N);

   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] snap_cnt;
   logic [10:0]      snap_pc;
   logic [15:0]      snap_acc;
   logic             cap_cpu;

   assign tx_wr = active && !tx_full;
   assign done  = tx_wr && (idx == IDX_W'(N - 1));

   // The CPU advances on the same edge that enters DUMP, so its pc/acc are
   // only final during the first DUMP cycle. Byte 0 is the constant header,
   // so grabbing them one cycle late never delays the frame.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         idx      <= '0;
         snap_cnt <= '0;
         snap_pc  <= '0;
         snap_acc <= '0;
         cap_cpu  <= 1'b0;
      end else begin
         cap_cpu <= start;
         if (start) begin
            snap_cnt <= cnt;
         end
         if (cap_cpu) begin
            snap_pc  <= pc;
            snap_acc <= acc;
         end
         if (done) begin
            idx <= '0;
         end else if (tx_wr) begin
            idx <= idx + 1'b1;
         end
      end
   end

   always_comb begin
      tx_data = FRAME_HDR;
      if (idx == IDX_W'(1)) tx_data = {5'b0, snap_pc[10:8]};
      if (idx == IDX_W'(2)) tx_data = snap_pc[7:0];
      if (idx == IDX_W'(3)) tx_data = snap_acc[15:8];
      if (idx == IDX_W'(4)) tx_data = snap_acc[7:0];
      for (int k = 0; k < CNT_BYTES; k++) begin
         if (idx == IDX_W'(5 + k)) tx_data = snap_cnt[CNT_W-1-8*k -: 8];
      end
   end

endmodule

// File: rtl/bip_run_ctrl.sv
// Run/step/debug sequencer for the BIP CPU.
// Accepts command bytes from the UART RX FIFO, gates the CPU with a clock
// enable, stops on the halt opcode and streams a pc/acc/cycle-count
// snapshot frame into the UART TX FIFO.
// Ports:
//   CLK, RESET            clock, async active-high reset
//   cmd_valid/cmd_byte    RX command byte, cmd_ready accept
//   instr, pc, acc        current CPU instruction / program counter / acc
//   cpu_en, cpu_rst       CPU clock enable and one-cycle soft reset
//   tx_full/tx_wr/tx_data TX FIFO interface
//   halted, busy          status; cycle_cnt counts cpu_en-high cycles
//
// Handshake: a command byte is transferred on every rising edge where
// cmd_valid && cmd_ready. cmd_ready depends only on state (IDLE or RUN), never
// on cmd_valid, so the RX side may hold cmd_valid until it is taken.
module bip_run_ctrl
   import bip_pkg::*;
#(
   parameter int         CNT_W  = 16,
   parameter logic [4:0] HLT_OP = 5'b00000
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             cmd_valid,
   input  logic [7:0]       cmd_byte,
   output logic             cmd_ready,
   input  logic [15:0]      instr,
   input  logic [10:0]      pc,
   input  logic [15:0]      acc,
   output logic             cpu_en,
   output logic             cpu_rst,
   input  logic             tx_full,
   output logic             tx_wr,
   output logic [7:0]       tx_data,
   output logic             halted,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_cnt
);

   run_state_t       state, state_nxt;
   logic             set_halt;
   logic             is_hlt;
   logic             cmd_acc;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dump_start, dump_done;
   logic             unused_operand;

   // Operand field is the CPU's business; only the opcode matters here.
   assign unused_operand = ^instr[10:0];

   assign is_hlt    = (opcode_of(instr) == HLT_OP);
   assign cmd_ready = (state == ST_IDLE) || (state == ST_RUN);
   assign cmd_acc   = cmd_valid && cmd_ready;
   // The halt instruction itself is never executed.
   assign cpu_en    = ((state == ST_RUN) || (state == ST_STEP)) && !is_hlt;
   assign cpu_rst   = (state == ST_CLR);
   assign busy      = (state != ST_IDLE);
   assign cycle_cnt = cnt;

   always_comb begin
      state_nxt = state;
      set_halt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_acc) begin
               case (cmd_byte)
                  CMD_RUN:   if (!halted) state_nxt = ST_RUN;
                  CMD_STEP:  if (!halted) state_nxt = ST_STEP;
                  CMD_PRINT: state_nxt = ST_DUMP;
                  CMD_CLEAR: state_nxt = ST_CLR;
                  default:   state_nxt = ST_IDLE;
               endcase
            end
         end
         ST_RUN: begin
            // Halt opcode beats a simultaneous 'H'; the byte is still consumed.
            if (is_hlt) begin
               set_halt  = 1'b1;
               state_nxt = ST_DUMP;
            end else if (cmd_acc && (cmd_byte == CMD_HALT)) begin
               state_nxt = ST_DUMP;
            end
         end
         ST_STEP: begin
            set_halt  = is_hlt;
            state_nxt = ST_DUMP;
         end
         ST_DUMP: begin
            if (dump_done) state_nxt = ST_IDLE;
         end
         ST_CLR: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Saturating counter; the snapshot takes cnt_nxt so the entry edge's
   // increment is included.
   always_comb begin
      cnt_nxt = cnt;
      if (state == ST_CLR) begin
         cnt_nxt = '0;
      end else if (cpu_en && (cnt != {CNT_W{1'b1}})) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   assign dump_start = (state_nxt == ST_DUMP) && (state != ST_DUMP);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         halted <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == ST_CLR) begin
            halted <= 1'b0;
         end else if (set_halt) begin
            halted <= 1'b1;
         end
      end
   end

   bip_dump_ser #(
      .CNT_W (CNT_W)
   ) u_ser (
      .CLK     (CLK),
      .RESET   (RESET),
      .start   (dump_start),
      .active  (state == ST_DUMP),
      .pc      (pc),
      .acc     (acc),
      .cnt     (cnt_nxt),
      .tx_full (tx_full),
      .tx_wr   (tx_wr),
      .tx_data (tx_data),
      .done    (dump_done)
   );

endmodule

// File: tb/tb_bip_run_ctrl.sv
module tb_bip_run_ctrl;

   localparam int CNT_W = 16;
   localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DUMP = 3, M_CLR = 4;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   logic             cmd_valid = 1'b0;
   logic [7:0]       cmd_byte = 8'h00;
   logic             cmd_ready;
   logic [15:0]      instr;
   logic [10:0]      pc;
   logic [15:0]      acc;
   logic             cpu_en, cpu_rst;
   logic             tx_full = 1'b0;
   logic             tx_wr;
   logic [7:0]       tx_data;
   logic             halted, busy;
   logic [CNT_W-1:0] cycle_cnt;

   bip_run_ctrl #(.CNT_W(CNT_W), .HLT_OP(5'b00000)) dut (
      .CLK(CLK), .RESET(RESET),
      .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
      .instr(instr), .pc(pc), .acc(acc),
      .cpu_en(cpu_en), .cpu_rst(cpu_rst),
      .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
      .halted(halted), .busy(busy), .cycle_cnt(cycle_cnt)
   );

   // ---------------- toy BIP CPU + program memory ----------------
   logic [15:0] prog [0:15];
   assign instr = prog[pc[3:0]];

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc <= '0; acc <= '0;
      end else if (cpu_rst) begin
         pc <= '0; acc <= '0;
      end else if (cpu_en) begin
         case (instr[15:11])
            5'b00011: begin acc <= {5'b0, instr[10:0]}; pc <= pc + 1'b1; end        // LDI
            5'b00101: begin acc <= acc + {5'b0, instr[10:0]}; pc <= pc + 1'b1; end  // ADDI
            5'b01000: pc <= instr[10:0];                                          // JMP
            default:  pc <= pc + 1'b1;
         endcase
      end
   end

   // ---------------- counters / check helper ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int               m_mode   = M_IDLE;
   logic             m_halted = 1'b0;
   logic [CNT_W-1:0] m_cnt    = '0;
   logic [CNT_W-1:0] m_snap   = '0;
   logic             m_fill   = 1'b0;   // first dump cycle: pc/acc not yet known
   logic [7:0]       exp_q[$];

   always @(posedge CLK or posedge RESET) begin : model
      logic hlt, en, take;
      if (RESET) begin
         m_mode = M_IDLE; m_halted = 1'b0; m_cnt = '0; m_snap = '0; m_fill = 1'b0;
         exp_q.delete();
      end else begin
         hlt  = (instr[15:11] == 5'b00000);
         en   = ((m_mode == M_RUN) || (m_mode == M_STEP)) && !hlt;
         take = cmd_valid && ((m_mode == M_IDLE) || (m_mode == M_RUN));
         if (en && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
         case (m_mode)
            M_IDLE: if (take) begin
               if (cmd_byte == 8'h52 && !m_halted) m_mode = M_RUN;
               else if (cmd_byte == 8'h53 && !m_halted) m_mode = M_STEP;
               else if (cmd_byte == 8'h50) begin m_mode = M_DUMP; m_fill = 1'b1; m_snap = m_cnt; end
               else if (cmd_byte == 8'h43) m_mode = M_CLR;
            end
            M_RUN: begin
               if (hlt) begin
                  m_halted = 1'b1; m_mode = M_DUMP; m_fill = 1'b1; m_snap = m_cnt;
               end else if (take && cmd_byte == 8'h48) begin
                  m_mode = M_DUMP; m_fill = 1'b1; m_snap = m_cnt;
               end
            end
            M_STEP: begin
               if (hlt) m_halted = 1'b1;
               m_mode = M_DUMP; m_fill = 1'b1; m_snap = m_cnt;
            end
            M_CLR: begin
               m_cnt = '0; m_halted = 1'b0; m_mode = M_IDLE;
            end
            M_DUMP: begin
               if (m_fill) begin
                  exp_q.push_back(8'hA5);
                  exp_q.push_back({5'b0, pc[10:8]});
                  exp_q.push_back(pc[7:0]);
                  exp_q.push_back(acc[15:8]);
                  exp_q.push_back(acc[7:0]);
                  for (int k = CNT_W / 8 - 1; k >= 0; k--) exp_q.push_back(8'((m_snap >> (8 * k)) & 8'hFF));
                  m_fill = 1'b0;
               end
               if (!tx_full && exp_q.size() > 0) begin
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) m_mode = M_IDLE;
               end
            end
            default: m_mode = M_IDLE;
         endcase
      end
   end

   // ---------------- compare process + frame capture ----------------
   logic [7:0] got_q[$];
   int en_cycles = 0, rst_cycles = 0, wr_cycles = 0;

   always @(negedge CLK) begin : compare
      logic hlt, exp_en, exp_wr;
      logic [7:0] exp_b;
      hlt    = (instr[15:11] == 5'b00000);
      exp_en = ((m_mode == M_RUN) || (m_mode == M_STEP)) && !hlt;
      exp_wr = (m_mode == M_DUMP) && !tx_full;
      check("cpu_en", cpu_en, exp_en);
      check("cpu_rst", cpu_rst, m_mode == M_CLR);
      check("cmd_ready", cmd_ready, (m_mode == M_IDLE) || (m_mode == M_RUN));
      check("busy", busy, m_mode != M_IDLE);
      check("halted", halted, m_halted);
      check("cycle_cnt", cycle_cnt, m_cnt);
      check("tx_wr", tx_wr, exp_wr);
      if (exp_wr) begin
         exp_b = m_fill ? 8'hA5 : ((exp_q.size() > 0) ? exp_q[0] : 8'hxx);
         check("tx_data", tx_data, exp_b);
      end
      if (tx_wr)   begin got_q.push_back(tx_data); wr_cycles++; end
      if (cpu_en)  en_cycles++;
      if (cpu_rst) rst_cycles++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick(); tick();
      RESET = 1'b0;
      tick();
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      cmd_valid = 1'b1; cmd_byte = b;
      forever begin
         @(negedge CLK);
         if (cmd_ready) break;
         t++;
         if (t > 200) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: byte %0h not accepted", b);
            break;
         end
      end
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int t = 0;
      @(negedge CLK);
      while (busy && t < max_cyc) begin @(negedge CLK); t++; end
      n_cmp++;
      if (busy) begin
         n_bad++;
         $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles", max_cyc);
      end
      @(posedge CLK); #1;
   endtask

   task automatic wait_bytes(input int base, input int nb);
      int t = 0;
      while (got_q.size() - base < nb && t < 200) begin @(negedge CLK); t++; end
      n_cmp++;
      if (got_q.size() - base < nb) begin
         n_bad++;
         $display("FAIL wait_bytes_timeout: got %0d bytes, need %0d", got_q.size() - base, nb);
      end
   endtask

   task automatic check_frame(input string name, input int base, input logic [55:0] e);
      check({name, "_len"}, 32'(got_q.size() - base), 7);
      for (int i = 0; i < 7; i++) begin
         if (base + i < got_q.size()) check({name, "_byte"}, got_q[base + i], e[55 - 8 * i -: 8]);
      end
   endtask

   task automatic load_prog(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2);
      for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
      prog[0] = p0; prog[1] = p1; prog[2] = p2;
   endtask

   // ---------------- directed test sequence ----------------
   int base, en_base, rst_base, wr_base;

   initial begin
      RESET = 1'b1;
      load_prog({5'b00011, 11'd3}, {5'b00101, 11'd4}, 16'h0000);  // LDI 3; ADDI 4; HLT
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_cycle_cnt", cycle_cnt, 0);
      check("rst_halted", halted, 0);

      // run to halt
      base = got_q.size(); en_base = en_cycles;
      send(8'h52);
      wait_idle(100);
      check("t1_en_cycles", 32'(en_cycles - en_base), 2);
      check("t1_halted", halted, 1);
      check("t1_cnt", cycle_cnt, 2);
      check_frame("t1_frame", base, 56'hA5_00_02_00_07_00_02);

      // halted: 'R' dropped, 'C' clears, 'P' prints cleared snapshot
      en_base = en_cycles;
      send(8'h52);
      repeat (3) tick();
      check("t5_r_dropped_en", 32'(en_cycles - en_base), 0);
      check("t5_r_dropped_busy", busy, 0);
      rst_base = rst_cycles;
      send(8'h43);
      tick();
      check("t5_rst_cycles", 32'(rst_cycles - rst_base), 1);
      check("t5_cnt", cycle_cnt, 0);
      check("t5_halted", halted, 0);
      base = got_q.size();
      send(8'h50);
      wait_idle(100);
      check_frame("t5_frame", base, 56'hA5_00_00_00_00_00_00);

      // two single steps from reset
      do_reset();
      base = got_q.size();
      send(8'h53);
      wait_idle(100);
      check_frame("t2_step1", base, 56'hA5_00_01_00_03_00_01);
      base = got_q.size();
      send(8'h53);
      wait_idle(100);
      check_frame("t2_step2", base, 56'hA5_00_02_00_07_00_02);
      check("t2_halted", halted, 0);

      // endless loop stopped by 'H'
      do_reset();
      load_prog({5'b00011, 11'd0}, {5'b00101, 11'd1}, {5'b01000, 11'd1});  // LDI 0; ADDI 1; JMP 1
      base = got_q.size();
      send(8'h52);
      repeat (9) tick();
      send(8'h48);
      wait_idle(100);
      check("t3_cnt", cycle_cnt, 10);
      check("t3_halted", halted, 0);
      check_frame("t3_frame", base, 56'hA5_00_02_00_05_00_0A);
      en_base = en_cycles;
      send(8'h52);
      repeat (4) tick();
      check("t3_resume_en", 32'(en_cycles - en_base), 4);
      send(8'h48);
      wait_idle(100);
      check("t3_cnt2", cycle_cnt, 15);

      // stall on byte 3
      base = got_q.size();
      send(8'h50);
      wait_bytes(base, 3);
      @(posedge CLK); #1;
      tx_full = 1'b1;
      wr_base = wr_cycles;
      repeat (5) tick();
      check("t4_stall_wr", 32'(wr_cycles - wr_base), 0);
      tx_full = 1'b0;
      wait_idle(100);
      check_frame("t4_frame", base, 56'hA5_00_01_00_07_00_0F);

      // reset in the middle of a frame
      base = got_q.size();
      send(8'h50);
      wait_bytes(base, 4);
      @(posedge CLK); #2;
      RESET = 1'b1;
      #1;
      check("t6_tx_wr", tx_wr, 0);
      check("t6_busy", busy, 0);
      check("t6_cmd_ready", cmd_ready, 1);
      check("t6_cnt", cycle_cnt, 0);
      @(posedge CLK); #1;
      RESET = 1'b0;
      send(8'h7A);
      check("t6_7a_busy", busy, 0);
      tick();
      check("t6_7a_busy2", busy, 0);
      check("t6_7a_halted", halted, 0);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
